// File: rtl/sha256_pkg.sv
// ---------------------------------------------------------------------------
// sha256_pkg
// Shared definitions for the SHA-256 message-schedule datapath:
//   W8_PAD / LEN_256 : fixed padding words for a single 256-bit message block
//   sigma0 / sigma1  : small-sigma functions of the W-schedule recurrence
//   fsm_state_t      : controller state (IDLE, RUN)
// ---------------------------------------------------------------------------
package sha256_pkg;

  localparam logic [31:0] W8_PAD  = 32'h8000_0000;
  localparam logic [31:0] LEN_256 = 32'h0000_0100;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fsm_state_t;

  // s0(x) = ROTR7 ^ ROTR18 ^ SHR3
  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  // s1(x) = ROTR17 ^ ROTR19 ^ SHR10
  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_w_next.sv
// ---------------------------------------------------------------------------
// sha256_w_next
// Combinational next-schedule-word generator:
//   W(t+16) = s1(W(t+14)) + W(t+9) + s0(W(t+1)) + W(t)   (mod 2^32)
// Ports:
//   w_t, w_t1, w_t9, w_t14 : window taps W(t), W(t+1), W(t+9), W(t+14)
//   w_t16                  : the new tail word W(t+16)
// ---------------------------------------------------------------------------
module sha256_w_next
  import sha256_pkg::*;
(
  input  logic [31:0] w_t,
  input  logic [31:0] w_t1,
  input  logic [31:0] w_t9,
  input  logic [31:0] w_t14,
  output logic [31:0] w_t16
);

  assign w_t16 = sigma1(w_t14) + w_t9 + sigma0(w_t1) + w_t;

endmodule

// File: rtl/sha256_w_sched_ctrl.sv
// ---------------------------------------------------------------------------
// sha256_w_sched_ctrl
// Accepts one 256-bit message block, pads it into a 16-word window and emits
// the SHA-256 message schedule W0..W(NUM_ROUNDS-1), one word per beat.
//
// Parameters:
//   NUM_ROUNDS : words emitted per block (17..64)
//   LEN_WORD   : length word placed in W15
// Ports:
//   CLK        : clock, rising edge
//   RST        : asynchronous reset, active low
//   in_valid / in_ready / block_in : block input handshake (W0 = [255:224])
//   out_valid / out_ready / w_out  : schedule word output stream
//   round_idx  : index t of w_out
//   last       : w_out is W(NUM_ROUNDS-1)
//   busy       : controller is emitting a block
// Configuration:
//   SHA256_WSCHED_BACKPRESSURE_EN : adds out_ready; without it every cycle in
//                                   RUN is an accepted beat.
// ---------------------------------------------------------------------------
module sha256_w_sched_ctrl
  import sha256_pkg::*;
#(
  parameter int          NUM_ROUNDS = 64,
  parameter logic [31:0] LEN_WORD   = LEN_256
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [255:0] block_in,
  output logic         out_valid,
`ifdef SHA256_WSCHED_BACKPRESSURE_EN
  input  logic         out_ready,
`endif
  output logic [31:0]  w_out,
  output logic [5:0]   round_idx,
  output logic         last,
  output logic         busy
);

  localparam logic [5:0] LAST_IDX = 6'(NUM_ROUNDS - 1);

  fsm_state_t  state;
  logic [31:0] win [16];   // win[0] is W(t), win[15] is W(t+15)
  logic [31:0] w_next;
  logic        beat;

  sha256_w_next u_w_next (
    .w_t   (win[0]),
    .w_t1  (win[1]),
    .w_t9  (win[9]),
    .w_t14 (win[14]),
    .w_t16 (w_next)
  );

  assign in_ready  = (state == IDLE);
  assign busy      = (state == RUN);
  assign out_valid = busy;
  assign w_out     = win[0];
  assign last      = out_valid && (round_idx == LAST_IDX);

`ifdef SHA256_WSCHED_BACKPRESSURE_EN
  assign beat = out_valid && out_ready;
`else
  assign beat = out_valid;
`endif

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values; the window shift depends on that.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      round_idx <= '0;
      // NOTE: the window is a register file, but it is reset explicitly
      // because w_out is taken straight from its head and must read 0.
      for (int i = 0; i < 16; i++) win[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < 8; i++) win[i] <= block_in[255 - 32*i -: 32];
            win[8] <= W8_PAD;
            for (int i = 9; i < 15; i++) win[i] <= '0;
            win[15]   <= LEN_WORD;
            round_idx <= '0;
            state     <= RUN;
          end
        end
        RUN: begin
          if (beat) begin
            for (int i = 0; i < 15; i++) win[i] <= win[i+1];
            win[15] <= w_next;
            // The counter saturates at the final index; the block ends there.
            if (last) state     <= IDLE;
            else      round_idx <= round_idx + 6'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_w_sched_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sha256_w_sched_ctrl
// Self-checking bench for sha256_w_sched_ctrl. A reference schedule is built
// with the textbook SHA-256 recurrence over a flat 64-entry array.
// Two instances: the default 64-round one and a 17-round one.
// ---------------------------------------------------------------------------
module tb_sha256_w_sched_ctrl;

  logic         CLK = 1'b0;
  logic         RST;
  logic         in_valid;
  logic [255:0] block_in;
  logic         in_ready, out_valid, last, busy;
  logic [31:0]  w_out;
  logic [5:0]   round_idx;
`ifdef SHA256_WSCHED_BACKPRESSURE_EN
  logic         out_ready;
`endif

  logic         in_valid17;
  logic [255:0] block_in17;
  logic         in_ready17, out_valid17, last17, busy17;
  logic [31:0]  w_out17;
  logic [5:0]   round_idx17;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_w [64];
  logic [31:0] obs_w [64];

  always #5 CLK = ~CLK;

  sha256_w_sched_ctrl dut (
    .CLK       (CLK),
    .RST       (RST),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .block_in  (block_in),
    .out_valid (out_valid),
`ifdef SHA256_WSCHED_BACKPRESSURE_EN
    .out_ready (out_ready),
`endif
    .w_out     (w_out),
    .round_idx (round_idx),
    .last      (last),
    .busy      (busy)
  );

  sha256_w_sched_ctrl #(.NUM_ROUNDS(17)) dut17 (
    .CLK       (CLK),
    .RST       (RST),
    .in_valid  (in_valid17),
    .in_ready  (in_ready17),
    .block_in  (block_in17),
    .out_valid (out_valid17),
`ifdef SHA256_WSCHED_BACKPRESSURE_EN
    .out_ready (1'b1),
`endif
    .w_out     (w_out17),
    .round_idx (round_idx17),
    .last      (last17),
    .busy      (busy17)
  );

  // ---------------- reference model ----------------
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ref_s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ref_s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  task automatic build_model(input logic [255:0] blk);
    for (int i = 0; i < 8; i++) exp_w[i] = blk[255 - 32*i -: 32];
    exp_w[8] = 32'h8000_0000;
    for (int i = 9; i < 15; i++) exp_w[i] = 32'h0;
    exp_w[15] = 32'h0000_0100;
    for (int i = 16; i < 64; i++)
      exp_w[i] = ref_s1(exp_w[i-2]) + exp_w[i-7] + ref_s0(exp_w[i-15]) + exp_w[i-16];
  endtask

  function automatic logic [255:0] rand_block();
    return {$urandom, $urandom, $urandom, $urandom,
            $urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- helpers driving stimulus ----------------
  // Presents blk while idle; it is taken on the next edge. Afterwards block_in
  // is scrambled so any late sampling would corrupt the schedule.
  task automatic accept(input logic [255:0] blk, input string tag);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_in_ready_before: got %b want 1", tag, in_ready);
    end
    in_valid = 1'b1;
    block_in = blk;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    block_in = rand_block();
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL %s_latency: out_valid got %b want 1 one cycle after accept", tag, out_valid);
    end
  endtask

  // Checks every emitted word against exp_w, then the return to idle.
  task automatic drain(input string tag);
    for (int t = 0; t < 64; t++) begin
      obs_w[t] = w_out;
      checks++;
      if (out_valid !== 1'b1 || round_idx !== 6'(t) || w_out !== exp_w[t] ||
          last !== (t == 63)) begin
        failures++;
        $display("FAIL %s_word%0d: valid=%b idx=%0d w=%h last=%b want valid=1 idx=%0d w=%h last=%b",
                 tag, t, out_valid, round_idx, w_out, last, t, exp_w[t], (t == 63));
      end
      @(posedge CLK); #1;
    end
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || last !== 1'b0) begin
      failures++;
      $display("FAIL %s_end: valid=%b ready=%b busy=%b last=%b want 0 1 0 0",
               tag, out_valid, in_ready, busy, last);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RST = 1'b0;
    in_valid = 1'b0;  block_in = '0;
    in_valid17 = 1'b0; block_in17 = '0;
`ifdef SHA256_WSCHED_BACKPRESSURE_EN
    out_ready = 1'b1;
`endif
    #2;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || w_out !== 32'h0 ||
        round_idx !== 6'd0 || last !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: rdy=%b vld=%b w=%h idx=%0d last=%b busy=%b want 1 0 0 0 0 0",
               in_ready, out_valid, w_out, round_idx, last, busy);
    end
    @(posedge CLK); #1;
    RST = 1'b1;
  endtask

  task automatic test_zero_block();
    build_model('0);
    accept('0, "zero");
    drain("zero");
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (obs_w[i] !== 32'h0) begin
        failures++;
        $display("FAIL zero_W%0d: got %h want 00000000", i, obs_w[i]);
      end
    end
    checks++;
    if (obs_w[8] !== 32'h8000_0000) begin
      failures++; $display("FAIL zero_W8: got %h want 80000000", obs_w[8]);
    end
    checks++;
    if (obs_w[15] !== 32'h0000_0100) begin
      failures++; $display("FAIL zero_W15: got %h want 00000100", obs_w[15]);
    end
    checks++;
    if (obs_w[16] !== 32'h0) begin
      failures++; $display("FAIL zero_W16: got %h want 00000000", obs_w[16]);
    end
    checks++;
    if (obs_w[17] !== 32'h00A0_0000) begin
      failures++; $display("FAIL zero_W17: got %h want 00a00000", obs_w[17]);
    end
  endtask

  task automatic test_reference();
    logic [255:0] blk;
    blk = 256'h0123456789abcdef_0123456789abcdef_0123456789abcdef_0123456789abcdef;
    build_model(blk);
    accept(blk, "ref");
    drain("ref");
    for (int k = 0; k < 3; k++) begin
      blk = rand_block();
      build_model(blk);
      accept(blk, "rand");
      drain("rand");
    end
  endtask

  task automatic test_busy_input();
    logic [255:0] blk_a, blk_b;
    blk_a = rand_block();
    blk_b = rand_block();
    build_model(blk_a);
    accept(blk_a, "busyA");
    for (int t = 0; t < 64; t++) begin
      checks++;
      if (round_idx !== 6'(t) || w_out !== exp_w[t]) begin
        failures++;
        $display("FAIL busyA_word%0d: idx=%0d w=%h want idx=%0d w=%h",
                 t, round_idx, w_out, t, exp_w[t]);
      end
      if (t >= 5) begin
        checks++;
        if (in_ready !== 1'b0) begin
          failures++;
          $display("FAIL busy_in_ready_t%0d: got %b want 0", t, in_ready);
        end
        in_valid = 1'b1;
        block_in = blk_b;
      end
      @(posedge CLK); #1;
    end
    // Block B is still offered and is taken on the edge after the last beat.
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL busy_gap: ready=%b valid=%b want 1 0", in_ready, out_valid);
    end
    @(posedge CLK); #1;
    in_valid = 1'b0;
    block_in = rand_block();
    build_model(blk_b);
    checks++;
    if (out_valid !== 1'b1 || round_idx !== 6'd0 || w_out !== exp_w[0]) begin
      failures++;
      $display("FAIL busyB_W0: valid=%b idx=%0d w=%h want 1 0 %h",
               out_valid, round_idx, w_out, exp_w[0]);
    end
    drain("busyB");
  endtask

`ifdef SHA256_WSCHED_BACKPRESSURE_EN
  task automatic test_backpressure();
    logic [255:0] blk;
    blk = rand_block();
    build_model(blk);
    accept(blk, "bp");
    for (int t = 0; t < 64; t++) begin
      checks++;
      if (out_valid !== 1'b1 || round_idx !== 6'(t) || w_out !== exp_w[t]) begin
        failures++;
        $display("FAIL bp_word%0d: valid=%b idx=%0d w=%h want 1 %0d %h",
                 t, out_valid, round_idx, w_out, t, exp_w[t]);
      end
      if (t == 20) begin
        out_ready = 1'b0;
        repeat (5) begin
          @(posedge CLK); #1;
          checks++;
          if (out_valid !== 1'b1 || round_idx !== 6'd20 || w_out !== exp_w[20] || last !== 1'b0) begin
            failures++;
            $display("FAIL bp_stall: valid=%b idx=%0d w=%h last=%b want 1 20 %h 0",
                     out_valid, round_idx, w_out, last, exp_w[20]);
          end
        end
        out_ready = 1'b1;
      end
      @(posedge CLK); #1;
    end
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_end: valid=%b ready=%b want 0 1", out_valid, in_ready);
    end
  endtask
`endif

  task automatic test_reset_mid_block();
    build_model('0);
    accept('0, "rstmid");
    repeat (30) begin
      @(posedge CLK); #1;
    end
    checks++;
    if (round_idx !== 6'd30 || w_out !== exp_w[30]) begin
      failures++;
      $display("FAIL rstmid_pre: idx=%0d w=%h want 30 %h", round_idx, w_out, exp_w[30]);
    end
    RST = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || round_idx !== 6'd0 || w_out !== 32'h0 ||
        in_ready !== 1'b1 || busy !== 1'b0 || last !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_async: vld=%b idx=%0d w=%h rdy=%b busy=%b last=%b want 0 0 0 1 0 0",
               out_valid, round_idx, w_out, in_ready, busy, last);
    end
    #2;
    RST = 1'b1;
    accept('0, "rstmid2");
    drain("rstmid2");
    checks++;
    if (obs_w[17] !== 32'h00A0_0000) begin
      failures++;
      $display("FAIL rstmid_W17: got %h want 00a00000", obs_w[17]);
    end
  endtask

  task automatic test_num_rounds_17();
    logic [255:0] blk;
    blk = rand_block();
    build_model(blk);
    checks++;
    if (in_ready17 !== 1'b1) begin
      failures++; $display("FAIL r17_ready: got %b want 1", in_ready17);
    end
    in_valid17 = 1'b1;
    block_in17 = blk;
    @(posedge CLK); #1;
    in_valid17 = 1'b0;
    block_in17 = rand_block();
    for (int t = 0; t < 17; t++) begin
      checks++;
      if (out_valid17 !== 1'b1 || round_idx17 !== 6'(t) || w_out17 !== exp_w[t] ||
          last17 !== (t == 16)) begin
        failures++;
        $display("FAIL r17_word%0d: valid=%b idx=%0d w=%h last=%b want 1 %0d %h %b",
                 t, out_valid17, round_idx17, w_out17, last17, t, exp_w[t], (t == 16));
      end
      @(posedge CLK); #1;
    end
    checks++;
    if (out_valid17 !== 1'b0 || in_ready17 !== 1'b1 || busy17 !== 1'b0) begin
      failures++;
      $display("FAIL r17_end: valid=%b ready=%b busy=%b want 0 1 0",
               out_valid17, in_ready17, busy17);
    end
  endtask

  initial begin
    test_reset();
    test_zero_block();
    test_reference();
    test_busy_input();
`ifdef SHA256_WSCHED_BACKPRESSURE_EN
    test_backpressure();
`endif
    test_reset_mid_block();
    test_num_rounds_17();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
